// File: rtl/silly_pkg.sv
// -----------------------------------------------------------------------------
// silly_pkg
//   Shared definitions for the silly step sequencer:
//     - state_t      : playback FSM states
//     - DEPTH_DEF    : default number of program steps
//     - HOLD_W_DEF   : default width of the per-step hold count
//     - step_t       : one program step (data byte + hold count) at the
//                      default hold width
// -----------------------------------------------------------------------------
package silly_pkg;

  localparam int DEPTH_DEF  = 8;
  localparam int HOLD_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0]            data;
    logic [HOLD_W_DEF-1:0] hold;
  } step_t;

endpackage

// File: rtl/silly_step_mem.sv
// -----------------------------------------------------------------------------
// silly_step_mem
//   DEPTH-entry register file holding the step program.
//   One synchronous write port, one combinational read port.
//
//   Ports:
//     clk      in   system clock
//     wr_en    in   write strobe
//     wr_addr  in   write slot
//     wr_rec   in   step record to store
//     rd_addr  in   read slot
//     rd_rec   out  step record at rd_addr (combinational)
// -----------------------------------------------------------------------------
module silly_step_mem #(
  parameter int  DEPTH = silly_pkg::DEPTH_DEF,
  parameter type rec_t = silly_pkg::step_t
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  rec_t                     wr_rec,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output rec_t                     rd_rec
);

  rec_t mem [DEPTH];

  // NOTE: the storage array has no reset on purpose; slots are only read
  // below the program count, which itself is reset, so stale contents are
  // never observed and the array can map onto plain flops or a RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_rec;
    end
  end

  assign rd_rec = mem[rd_addr];

endmodule

// File: rtl/silly_step_sequencer.sv
// -----------------------------------------------------------------------------
// silly_step_sequencer
//   Programmable step sequencer for the silly datapath. The host appends
//   steps (data byte + hold count) while idle; on start the steps are played
//   onto dp_in back to back, each for hold+1 cycles, optionally looping.
//   dp_out is captured in the final cycle of every step.
//
//   Ports:
//     clk, rst_n  in   clock, asynchronous active-low reset
//     wr_en       in   append one step (idle only)
//     wr_data     in   step data byte
//     wr_hold     in   step hold count
//     clr         in   empty the program (idle only)
//     start       in   begin playback (pulse)
//     stop        in   abort playback (pulse)
//     loop        in   wrap to step 0 after the last step
//     dp_out      in   datapath output, sampled for capture
//     dp_in       out  datapath input bus (registered)
//     busy        out  playback in progress (RUN or DONE)
//     full        out  program holds DEPTH steps
//     step_idx    out  index of the step currently driven
//     capture     out  last captured dp_out
//     cap_valid   out  one-cycle pulse when capture updates
// -----------------------------------------------------------------------------
module silly_step_sequencer
  import silly_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int HOLD_W = HOLD_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic [HOLD_W-1:0]        wr_hold,
  input  logic                     clr,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop,
  input  logic [7:0]               dp_out,
  output logic [7:0]               dp_in,
  output logic                     busy,
  output logic                     full,
  output logic [$clog2(DEPTH)-1:0] step_idx,
  output logic [7:0]               capture,
  output logic                     cap_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;  // count spans 0..DEPTH inclusive

  typedef struct packed {
    logic [7:0]        data;
    logic [HOLD_W-1:0] hold;
  } rec_t;

  state_t            state;
  logic [CW-1:0]     count;
  logic [HOLD_W-1:0] hold_cnt;

  logic              last_step;
  logic              wr_accept;
  logic [AW-1:0]     rd_addr;
  rec_t              rd_rec;
  rec_t              wr_rec;

  assign busy = (state != IDLE);
  assign full = (count == CW'(DEPTH));

  // A write wins over start, loses to clr, and is dropped when full.
  assign wr_accept = (state == IDLE) && !clr && wr_en && !full;
  assign wr_rec    = '{data: wr_data, hold: wr_hold};

  assign last_step = ({1'b0, step_idx} == (count - CW'(1)));

  // The single read port always presents the step that will be loaded next:
  // step 0 when starting or wrapping, otherwise the following step.
  assign rd_addr = (state == RUN && !last_step) ? step_idx + AW'(1) : '0;

  silly_step_mem #(
    .DEPTH (DEPTH),
    .rec_t (rec_t)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (count[AW-1:0]),
    .wr_rec  (wr_rec),
    .rd_addr (rd_addr),
    .rd_rec  (rd_rec)
  );

  // NOTE: all state here is assigned with non-blocking (<=) so every
  // register samples values from before the edge; blocking assignments would
  // let later statements see half-updated state and break the hold countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      hold_cnt  <= '0;
      step_idx  <= '0;
      dp_in     <= '0;
      capture   <= '0;
      cap_valid <= 1'b0;
    end else begin
      cap_valid <= 1'b0;

      case (state)
        IDLE: begin
          dp_in <= '0;
          if (clr) begin
            count <= '0;
          end else if (wr_en) begin
            if (!full) begin
              count <= count + CW'(1);
            end
          end else if (start && !stop && (count != '0)) begin
            state    <= RUN;
            dp_in    <= rd_rec.data;
            hold_cnt <= rd_rec.hold;
            step_idx <= '0;
          end
        end

        RUN: begin
          if (stop) begin
            state    <= IDLE;
            dp_in    <= '0;
            step_idx <= '0;
          end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end else begin
            // Final cycle of the current step: dp_out still reflects it.
            capture   <= dp_out;
            cap_valid <= 1'b1;
            if (!last_step) begin
              step_idx <= step_idx + AW'(1);
              dp_in    <= rd_rec.data;
              hold_cnt <= rd_rec.hold;
            end else if (loop) begin
              step_idx <= '0;
              dp_in    <= rd_rec.data;
              hold_cnt <= rd_rec.hold;
            end else begin
              state    <= DONE;
              dp_in    <= '0;
              step_idx <= '0;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          dp_in <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_silly_step_sequencer.sv
// -----------------------------------------------------------------------------
// tb_silly_step_sequencer
//   Self-checking bench for silly_step_sequencer. A stand-in datapath
//   (dp_out = dp_in ^ 0xA5) lets expected captures be derived from the
//   programmed data bytes.
// -----------------------------------------------------------------------------
module tb_silly_step_sequencer;

  localparam logic [7:0] XK = 8'hA5;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic [3:0] wr_hold;
  logic       clr;
  logic       start;
  logic       stop;
  logic       loop;
  logic [7:0] dp_out;
  logic [7:0] dp_in;
  logic       busy;
  logic       full;
  logic [2:0] step_idx;
  logic [7:0] capture;
  logic       cap_valid;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] got_caps[$];
  logic [7:0] ref_caps[$];

  silly_step_sequencer #(
    .DEPTH  (8),
    .HOLD_W (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_hold   (wr_hold),
    .clr       (clr),
    .start     (start),
    .stop      (stop),
    .loop      (loop),
    .dp_out    (dp_out),
    .dp_in     (dp_in),
    .busy      (busy),
    .full      (full),
    .step_idx  (step_idx),
    .capture   (capture),
    .cap_valid (cap_valid)
  );

  assign dp_out = dp_in ^ XK;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       wr_en;
    logic       clr;
    logic       start;
    logic       stop;
    logic       loop;
    logic [7:0] data;
    logic [3:0] hold;
    logic [7:0] e_dp_in;
    logic       e_busy;
    logic       e_cv;
    logic [7:0] e_cap;
    logic       e_full;
    logic [2:0] e_idx;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; clr = 1'b0; start = 1'b0; stop = 1'b0;
    wr_data = 8'h00; wr_hold = 4'h0;
  endtask

  task automatic write_step(input logic [7:0] d, input logic [3:0] h);
    wr_en = 1'b1; wr_data = d; wr_hold = h;
    tick();
    wr_en = 1'b0;
  endtask

  // Ticks until busy drops, collecting every capture pulse.
  task automatic run_to_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      if (cap_valid) got_caps.push_back(capture);
      n++;
    end
    check("run ends within budget", 32'(busy), 32'd0);
  endtask

  task automatic check_caps(input string name);
    check({name, " capture count"}, 32'(got_caps.size()), 32'(ref_caps.size()));
    for (int i = 0; i < ref_caps.size() && i < got_caps.size(); i++)
      check($sformatf("%s capture[%0d]", name, i), 32'(got_caps[i]), 32'(ref_caps[i]));
  endtask

  function automatic vec_t mk(logic w, logic c, logic s, logic p, logic l,
                              logic [7:0] d, logic [3:0] h,
                              logic [7:0] edp, logic eb, logic ecv,
                              logic [7:0] ecap, logic ef, logic [2:0] ei);
    vec_t v;
    v.wr_en = w; v.clr = c; v.start = s; v.stop = p; v.loop = l;
    v.data = d; v.hold = h;
    v.e_dp_in = edp; v.e_busy = eb; v.e_cv = ecv;
    v.e_cap = ecap; v.e_full = ef; v.e_idx = ei;
    return v;
  endfunction

  // Program used by the loop and run tests.
  logic [7:0] pd[3];
  logic [3:0] ph[3];

  initial begin
    logic [7:0] exp_dp[$];
    logic       exp_last[$];

    pd[0] = 8'h11; ph[0] = 4'd0;
    pd[1] = 8'h22; ph[1] = 4'd2;
    pd[2] = 8'h33; ph[2] = 4'd1;

    //               w  c  s  p  l  data   h     dp_in  bsy cv cap    full idx
    vecs[0]  = mk(1, 0, 0, 0, 0, 8'h11, 4'd0, 8'h00, 0, 0, 8'h00, 0, 3'd0);
    vecs[1]  = mk(1, 0, 0, 0, 0, 8'h22, 4'd2, 8'h00, 0, 0, 8'h00, 0, 3'd0);
    vecs[2]  = mk(1, 0, 0, 0, 0, 8'h33, 4'd1, 8'h00, 0, 0, 8'h00, 0, 3'd0);
    vecs[3]  = mk(0, 0, 1, 0, 0, 8'h00, 4'd0, 8'h11, 1, 0, 8'h00, 0, 3'd0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 8'h00, 4'd0, 8'h22, 1, 1, 8'hB4, 0, 3'd1);
    vecs[5]  = mk(0, 0, 0, 0, 0, 8'h00, 4'd0, 8'h22, 1, 0, 8'hB4, 0, 3'd1);
    vecs[6]  = mk(0, 0, 0, 0, 0, 8'h00, 4'd0, 8'h22, 1, 0, 8'hB4, 0, 3'd1);
    vecs[7]  = mk(0, 0, 0, 0, 0, 8'h00, 4'd0, 8'h33, 1, 1, 8'h87, 0, 3'd2);
    vecs[8]  = mk(0, 0, 0, 0, 0, 8'h00, 4'd0, 8'h33, 1, 0, 8'h87, 0, 3'd2);
    vecs[9]  = mk(0, 0, 0, 0, 0, 8'h00, 4'd0, 8'h00, 1, 1, 8'h96, 0, 3'd0);
    vecs[10] = mk(0, 0, 0, 0, 0, 8'h00, 4'd0, 8'h00, 0, 0, 8'h96, 0, 3'd0);

    ref_caps.push_back(8'hB4);
    ref_caps.push_back(8'h87);
    ref_caps.push_back(8'h96);

    // ---------------- reset state ----------------
    idle_inputs();
    loop  = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset dp_in", 32'(dp_in), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset full", 32'(full), 32'd0);
    check("reset capture", 32'(capture), 32'd0);
    check("reset cap_valid", 32'(cap_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ---------------- table: load 3 steps and play once ----------------
    for (int i = 0; i < 11; i++) begin
      wr_en = vecs[i].wr_en; clr = vecs[i].clr; start = vecs[i].start;
      stop = vecs[i].stop; loop = vecs[i].loop;
      wr_data = vecs[i].data; wr_hold = vecs[i].hold;
      tick();
      check($sformatf("v%0d dp_in", i),     32'(dp_in),     32'(vecs[i].e_dp_in));
      check($sformatf("v%0d busy", i),      32'(busy),      32'(vecs[i].e_busy));
      check($sformatf("v%0d cap_valid", i), 32'(cap_valid), 32'(vecs[i].e_cv));
      check($sformatf("v%0d capture", i),   32'(capture),   32'(vecs[i].e_cap));
      check($sformatf("v%0d full", i),      32'(full),      32'(vecs[i].e_full));
      check($sformatf("v%0d step_idx", i),  32'(step_idx),  32'(vecs[i].e_idx));
    end
    idle_inputs();

    // ---------------- loop: two passes, wrap with no gap, then stop ----------------
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 3; k++)
        for (int c = 0; c <= int'(ph[k]); c++) begin
          exp_dp.push_back(pd[k]);
          exp_last.push_back(c == int'(ph[k]));
        end
    exp_dp.push_back(pd[0]);
    exp_last.push_back(1'b1);

    loop = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("loop first dp_in", 32'(dp_in), 32'(exp_dp[0]));
    for (int i = 1; i < exp_dp.size(); i++) begin
      tick();
      check($sformatf("loop t%0d dp_in", i), 32'(dp_in), 32'(exp_dp[i]));
      check($sformatf("loop t%0d cap_valid", i), 32'(cap_valid), 32'(exp_last[i-1]));
      if (exp_last[i-1])
        check($sformatf("loop t%0d capture", i), 32'(capture), 32'(exp_dp[i-1] ^ XK));
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop busy", 32'(busy), 32'd0);
    check("stop dp_in", 32'(dp_in), 32'd0);
    check("stop cap_valid", 32'(cap_valid), 32'd0);

    // restart replays from step 0
    loop = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("restart dp_in", 32'(dp_in), 32'h11);
    check("restart busy", 32'(busy), 32'd1);
    got_caps.delete();
    run_to_idle(30);
    check_caps("restart");

    // ---------------- wr_en / clr during RUN are ignored ----------------
    start = 1'b1;
    tick();
    start = 1'b0;
    got_caps.delete();
    wr_en = 1'b1; clr = 1'b1; wr_data = 8'hEE; wr_hold = 4'h5;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cap_valid) got_caps.push_back(capture);
    end
    idle_inputs();
    run_to_idle(30);
    check_caps("run with wr/clr");
    start = 1'b1;
    tick();
    start = 1'b0;
    got_caps.delete();
    run_to_idle(30);
    check_caps("second run");

    // ---------------- reset mid-RUN ----------------
    clr = 1'b1;
    tick();
    clr = 1'b0;
    write_step(8'h5A, 4'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("pre-reset dp_in", 32'(dp_in), 32'h5A);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset dp_in", 32'(dp_in), 32'd0);
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset step_idx", 32'(step_idx), 32'd0);
    check("async reset capture", 32'(capture), 32'd0);
    check("async reset cap_valid", 32'(cap_valid), 32'd0);
    check("async reset full", 32'(full), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- IDLE corner cases ----------------
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start with empty program busy", 32'(busy), 32'd0);

    start = 1'b1; wr_en = 1'b1; wr_data = 8'h3C; wr_hold = 4'd1;
    tick();
    idle_inputs();
    check("start+wr_en busy", 32'(busy), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("write accepted dp_in", 32'(dp_in), 32'h3C);
    got_caps.delete();
    run_to_idle(20);
    ref_caps.delete();
    ref_caps.push_back(8'h3C ^ XK);
    check_caps("single step");

    start = 1'b1; stop = 1'b1;
    tick();
    idle_inputs();
    check("start+stop busy", 32'(busy), 32'd0);
    check("start+stop dp_in", 32'(dp_in), 32'd0);

    // ---------------- full: 9 writes into 8 slots ----------------
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr empties full", 32'(full), 32'd0);
    for (int i = 0; i < 9; i++) begin
      write_step(8'h80 + 8'(i), 4'd0);
      check($sformatf("full after write %0d", i + 1), 32'(full), 32'(i >= 7));
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check("full run first dp_in", 32'(dp_in), 32'h80);
    got_caps.delete();
    run_to_idle(40);
    ref_caps.delete();
    for (int i = 0; i < 8; i++) ref_caps.push_back((8'h80 + 8'(i)) ^ XK);
    check_caps("full program");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
